mem_io_responder: RTL

Data-side bus responder for the RISC-V core. It serves the core's load/store requests (addr, memWdata, memWMask, read strobe) and returns memRdata. It contains a byte-maskable word RAM and a small IO page with an LED register and a free-running cycle counter. A programmable wait-state FSM inserts stalls via memBusy, so the core sees a realistic multi-cycle memory.

---
 rtl/mem_io_pkg.sv | 8 +
 rtl/bram_wmask.sv | 24 ++
 rtl/mem_io_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_io_pkg.sv
// Shared constants and FSM state type for the data-side memory/IO responder.
package mem_io_pkg;
  localparam int         IO_SEL_BIT = 22;
  localparam logic [2:0] IO_LED_OFS = 3'd0;
  localparam logic [2:0] IO_CNT_OFS = 3'd1;

  typedef enum logic {IDLE, WAIT} state_t;
endpackage

// File: rtl/bram_wmask.sv
// Synchronous word RAM with per-byte write enables and a registered,
// read-before-write output that only updates when a read is requested.
module bram_wmask #(
  parameter int MEM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         i_rd,
  input  logic [3:0]                   i_we,
  input  logic [$clog2(MEM_WORDS)-1:0] i_addr,
  input  logic [31:0]                  i_wdata,
  output logic [31:0]                  o_rdata
);
  logic [31:0] r_mem [MEM_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_rd) r_rdata <= r_mem[i_addr];
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_io_responder.sv
// Data-bus responder: byte-maskable RAM plus LED/cycle-counter IO page,
// with a programmable number of wait states signalled on memBusy.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 1,
  parameter int LED_WIDTH   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic [31:0]          memWdata,
  input  logic [3:0]           memWMask,
  input  logic                 memRstrb,
  output logic [31:0]          memRdata,
  output logic                 memBusy,
  output logic [LED_WIDTH-1:0] leds
);
  localparam int AW = $clog2(MEM_WORDS);

  state_t               r_state;
  logic [3:0]           r_wcnt;
  logic                 r_busy;
  logic [LED_WIDTH-1:0] r_leds;
  logic [31:0]          r_cnt;
  logic [31:0]          r_io_rd;
  logic                 r_src_ram;

  logic                 w_req;
  logic                 w_access;
  logic                 w_is_io;
  logic [2:0]           w_io_ofs;
  logic [AW-1:0]        w_ram_idx;
  logic [31:0]          w_io_rdata;
  logic [31:0]          w_ram_rdata;
  logic [3:0]           w_ram_we;
  logic                 w_ram_rd;
  logic                 w_unused_addr;

  assign w_req     = memRstrb | (|memWMask);
  assign w_is_io   = addr[IO_SEL_BIT];
  assign w_io_ofs  = addr[4:2];
  assign w_ram_idx = addr[AW+1:2];
  assign w_unused_addr = ^{addr[31:IO_SEL_BIT+1], addr[IO_SEL_BIT-1:AW+2], addr[1:0]};

  // Gating with reset keeps an edge seen during reset from committing a write.
  always_comb begin
    w_access = 1'b0;
    if (WAIT_STATES == 0) w_access = reset & (r_state == IDLE) & w_req;
    else                  w_access = reset & (r_state == WAIT) & (r_wcnt == 4'd1);
  end

  always_comb begin
    w_io_rdata = 32'd0;
    case (w_io_ofs)
      IO_LED_OFS: w_io_rdata = {{(32-LED_WIDTH){1'b0}}, r_leds};
      IO_CNT_OFS: w_io_rdata = r_cnt;
      default:    w_io_rdata = 32'd0;
    endcase
  end

  assign w_ram_rd = w_access & memRstrb & ~w_is_io;
  assign w_ram_we = (w_access & ~w_is_io) ? memWMask : 4'b0000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_wcnt  <= 4'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && (WAIT_STATES != 0)) begin
            r_state <= WAIT;
            r_wcnt  <= 4'(WAIT_STATES);
            r_busy  <= 1'b1;
          end
        end
        WAIT: begin
          r_wcnt <= r_wcnt - 4'd1;
          if (r_wcnt == 4'd1) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // r_src_ram steers memRdata; pure writes leave both it and the RAM output alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_leds    <= '0;
      r_cnt     <= 32'd0;
      r_io_rd   <= 32'd0;
      r_src_ram <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_access) begin
        if (memRstrb) begin
          r_src_ram <= ~w_is_io;
          if (w_is_io) r_io_rd <= w_io_rdata;
        end
        if (w_is_io && (w_io_ofs == IO_LED_OFS) && memWMask[0])
          r_leds <= memWdata[LED_WIDTH-1:0];
      end
    end
  end

  bram_wmask #(.MEM_WORDS(MEM_WORDS)) u_bram (
    .clk     (clk),
    .i_rd    (w_ram_rd),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_idx),
    .i_wdata (memWdata),
    .o_rdata (w_ram_rdata)
  );

  assign memRdata = r_src_ram ? w_ram_rdata : r_io_rd;
  assign memBusy  = r_busy;
  assign leds     = r_leds;
endmodule
